// File: rtl/branch_predictor_if.sv
// Bundles the fetch lookup, EX resolution/training and statistics signals of the branch predictor.
interface branch_predictor_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic [XLEN-1:0]  pc_if;
  logic             pred_taken_if;
  logic [XLEN-1:0]  pred_target_if;
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_pred_taken;
  logic [XLEN-1:0]  upd_pred_target;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic             clear_stats;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output pc_if, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, clear_stats,
    input  pred_taken_if, pred_target_if, mispredict, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  pc_if, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, clear_stats,
    output pred_taken_if, pred_target_if, mispredict, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency IF lookup,
// EX-stage training, mispredict/redirect generation and saturating statistics.
module branch_predictor #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned PREDICT_EN = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rstn,
  branch_predictor_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [CNT_W-1:0] branch_count_q;
  logic [CNT_W-1:0] mispredict_count_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             mispredict_c;

  assign lk_idx = bus.pc_if[IDX_W+1:2];
  assign lk_tag = bus.pc_if[XLEN-1:IDX_W+2];
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[XLEN-1:IDX_W+2];

  // Fetch lookup reads pre-update table state; no write bypass.
  always_comb begin
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken = (PREDICT_EN != 0) && lk_hit && ctr_q[lk_idx][1];
    bus.pred_taken_if  = lk_taken;
    bus.pred_target_if = lk_taken ? target_q[lk_idx] : bus.pc_if + XLEN'(4);
  end

  always_comb begin
    up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    mispredict_c = bus.upd_valid &&
                   ((bus.upd_taken != bus.upd_pred_taken) ||
                    (bus.upd_taken && bus.upd_pred_taken &&
                     (bus.upd_target != bus.upd_pred_target)));
    bus.mispredict  = mispredict_c;
    bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);
  end

  // Table training: hits move the counter, taken misses allocate weakly-taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        if (bus.upd_taken) begin
          target_q[up_idx] <= bus.upd_target;
          if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.upd_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

  // Saturating statistics; clear wins over same-cycle increments.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (bus.clear_stats) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (bus.upd_valid && (branch_count_q != '1))
        branch_count_q <= branch_count_q + CNT_W'(1);
      if (mispredict_c && (mispredict_count_q != '1))
        mispredict_count_q <= mispredict_count_q + CNT_W'(1);
    end
  end

  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor (ENTRIES=16, CNT_W=4).
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(32), .CNT_W(4)) bus ();

  branch_predictor #(.XLEN(32), .ENTRIES(16), .PREDICT_EN(1), .CNT_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int          kind;   // 0 lookup, 1 resolution, 2 statistics
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    errors = 0;
  int    checks = 0;

  task automatic push(input int kind, input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.kind = kind; e.e1 = e1; e.e2 = e2;
    q.push_back(e);
    nq.push_back(name);
  endtask

  task automatic drain();
    exp_t        e;
    string       n;
    logic [31:0] o1, o2;
    while (q.size() > 0) begin
      e = q.pop_front();
      n = nq.pop_front();
      case (e.kind)
        0:       begin o1 = 32'(bus.pred_taken_if); o2 = bus.pred_target_if; end
        1:       begin o1 = 32'(bus.mispredict);    o2 = bus.redirect_pc;    end
        default: begin o1 = 32'(bus.branch_count);  o2 = 32'(bus.mispredict_count); end
      endcase
      checks++;
      assert ({o1, o2} === {e.e1, e.e2}) else begin
        errors++;
        $error("FAIL %s: observed %0h/%0h expected %0h/%0h", n, o1, o2, e.e1, e.e2);
      end
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic upt,
                       input logic [31:0] uptgt, input logic clr);
    bus.pc_if = pc; bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_taken = ut;
    bus.upd_target = utgt; bus.upd_pred_taken = upt; bus.upd_pred_target = uptgt;
    bus.clear_stats = clr;
  endtask

  task automatic idle(input logic [31:0] pc);
    drive(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Compare on the falling edge, then advance past the next rising edge.
  task automatic step();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle(32'h40);
    push(0, "reset_lookup", 32'd0, 32'h44);
    push(2, "reset_stats", 32'd0, 32'd0);
    step();
    rstn = 1'b1;

    // First allocation: same-cycle lookup sees the old (empty) entry
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    push(0, "alloc_same_cycle", 32'd0, 32'h44);
    push(1, "alloc_resolve", 32'd1, 32'h10);
    step();
    idle(32'h40);
    push(0, "alloc_next_cycle", 32'd1, 32'h10);
    push(2, "stats_after_alloc", 32'd1, 32'd1);
    step();

    // Hysteresis: 2 -> 1 (predict not taken)
    drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
    push(0, "hyst_pre_nt", 32'd1, 32'h10);
    push(1, "hyst_nt_resolve", 32'd1, 32'h44);
    step();
    idle(32'h40);
    push(0, "hyst_ctr1", 32'd0, 32'h44);
    push(2, "stats_hyst", 32'd2, 32'd2);
    step();

    // Three taken updates: 1 -> 2 -> 3 -> 3
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    push(1, "hyst_t1", 32'd1, 32'h10);
    step();
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h10, 1'b1, 32'h10, 1'b0);
    push(1, "hyst_t2_correct", 32'd0, 32'h10);
    step();
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h10, 1'b1, 32'h10, 1'b0);
    push(1, "hyst_t3_correct", 32'd0, 32'h10);
    step();
    drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
    push(1, "hyst_nt_from_sat", 32'd1, 32'h44);
    step();
    idle(32'h40);
    push(0, "hyst_still_taken", 32'd1, 32'h10);
    push(2, "stats_sat_ctr", 32'd6, 32'd4);
    step();

    // Target change on a hit
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b1, 32'h10, 1'b0);
    push(1, "target_change", 32'd1, 32'h20);
    step();
    idle(32'h40);
    push(0, "new_target", 32'd1, 32'h20);
    step();

    // Aliasing: 0x80 replaces 0x40 at index 0
    drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0);
    push(0, "alias_pre", 32'd0, 32'h84);
    push(1, "alias_resolve", 32'd1, 32'h30);
    step();
    idle(32'h40);
    push(0, "alias_victim_miss", 32'd0, 32'h44);
    step();
    // Not-taken miss at 0x100 must leave index 0 untouched
    drive(32'h80, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    push(0, "alias_new_hit", 32'd1, 32'h30);
    push(1, "nt_miss_resolve", 32'd0, 32'h104);
    step();
    idle(32'h80);
    push(0, "nt_miss_no_change", 32'd1, 32'h30);
    push(2, "stats_mid", 32'd9, 32'd6);
    step();

    // Same-cycle read/write on a fresh index
    drive(32'h44, 1'b1, 32'h44, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    push(0, "rw_same_cycle", 32'd0, 32'h48);
    push(1, "rw_resolve", 32'd1, 32'h200);
    step();
    idle(32'h44);
    push(0, "rw_next_cycle", 32'd1, 32'h200);
    step();
    idle(32'hFFFF_FFFC);
    push(0, "pc_wrap", 32'd0, 32'h0);
    step();

    // Statistics saturation (branch_count 10 -> 18 clips at 15)
    for (int i = 0; i < 8; i++) begin
      drive(32'h44, 1'b1, 32'h44, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
      step();
    end
    idle(32'h44);
    push(2, "stats_saturated", 32'd15, 32'd7);
    step();
    drive(32'h44, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    push(1, "clear_resolve", 32'd1, 32'h48);
    step();
    idle(32'h44);
    push(2, "stats_cleared", 32'd0, 32'd0);
    step();
    drive(32'h44, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    step();
    idle(32'h80);
    push(2, "stats_after_clear", 32'd1, 32'd1);
    push(0, "pre_reset_hit", 32'd1, 32'h30);
    step();

    // Asynchronous reset mid-operation clears tables at once
    rstn = 1'b0;
    #1;
    push(0, "async_reset_lookup", 32'd0, 32'h84);
    push(2, "async_reset_stats", 32'd0, 32'd0);
    drain();
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    idle(32'h44);
    push(0, "post_reset_miss", 32'd0, 32'h48);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
